binary_to_bcd_converter: RTL



---
 rtl/binary_to_bcd_converter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/binary_to_bcd_converter.sv
`default_nettype none
// ============================================================================
//  Module      : binary_to_bcd_converter
//  Description : Iterative double-dabble converter, one bit per clock, driving
//                eight packed BCD digits with saturation above 99_999_999.
//  Revision    : 1.0  initial release
// ============================================================================
module binary_to_bcd_converter #(
   parameter int WIDTH = 27
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic [WIDTH-1:0] bin_in,
   input  logic             valid_in,
   output logic             ready_out,
   output logic [31:0]      bcd_out,
   output logic             valid_out,
   output logic             overflow_out
);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   localparam logic [26:0] C_MAX_DEC   = 27'd99_999_999;
   localparam logic [31:0] C_SATURATE  = 32'h9999_9999;
   localparam logic [4:0]  C_LAST_SHIFT = 5'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] bin_q, bin_d;
   logic [31:0]      scr_q, scr_d;
   logic [4:0]       cnt_q, cnt_d;
   logic             flag_q, flag_d;
   logic [31:0]      bcd_q, bcd_d;
   logic             ovf_q, ovf_d;
   logic             valid_q, valid_d;

   logic [31:0]      corr;
   logic [31:0]      shifted;
   logic [26:0]      bin_ext;

   // A nibble of at most 9 becomes at most 12 after +3, so 4 bits suffice.
   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_nib
         assign corr[4*gi +: 4] = (scr_q[4*gi +: 4] >= 4'd5) ?
                                  (scr_q[4*gi +: 4] + 4'd3) : scr_q[4*gi +: 4];
      end
   endgenerate

   assign shifted = {corr[30:0], bin_q[WIDTH-1]};

   always_comb begin
      bin_ext              = '0;
      bin_ext[WIDTH-1:0]   = bin_in;
   end

   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      scr_d   = scr_q;
      cnt_d   = cnt_q;
      flag_d  = flag_q;
      bcd_d   = bcd_q;
      ovf_d   = ovf_q;
      valid_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (valid_in) begin
               bin_d   = bin_in;
               scr_d   = '0;
               flag_d  = (bin_ext > C_MAX_DEC);
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            scr_d = shifted;
            bin_d = bin_q << 1;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == C_LAST_SHIFT) begin
               state_d = IDLE;
               valid_d = 1'b1;
               bcd_d   = flag_q ? C_SATURATE : shifted;
               ovf_d   = flag_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q <= IDLE;
         bin_q   <= '0;
         scr_q   <= '0;
         cnt_q   <= '0;
         flag_q  <= 1'b0;
         bcd_q   <= '0;
         ovf_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         scr_q   <= scr_d;
         cnt_q   <= cnt_d;
         flag_q  <= flag_d;
         bcd_q   <= bcd_d;
         ovf_q   <= ovf_d;
         valid_q <= valid_d;
      end
   end

   // Ready is decoded straight from the state register, so it stays registered.
   assign ready_out    = (state_q == IDLE);
   assign bcd_out      = bcd_q;
   assign valid_out    = valid_q;
   assign overflow_out = ovf_q;

endmodule
`default_nettype wire
